// File: rtl/vecmac_pkg.sv
// Shared definitions for the vecmac accumulate/drain slice: default tree
// geometry, the tree sum width calculation and the drain FSM state type.
package vecmac_pkg;

  localparam int DEF_LANES = 4;
  localparam int DEF_INW   = 16;

  // Adder-tree depth. Trees narrower than 4 lanes still use 2 stages.
  function automatic int calc_stages(input int lanes);
    return (lanes < 4) ? 2 : $clog2(lanes);
  endfunction

  // Width of one tree output beat: product width plus growth through the tree.
  function automatic int calc_sumw(input int lanes, input int inw);
    return inw + calc_stages(lanes) + 1;
  endfunction

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ACCUM = 1'b1
  } acc_state_e;

endpackage

// File: rtl/vecmac_res_fifo.sv
// Synchronous first-word-fall-through result FIFO. The head entry is visible
// on head whenever empty is low. A push while full is accepted only when a
// pop happens on the same edge; otherwise the caller sees the drop.
// head reads as zero while the FIFO is empty.
module vecmac_res_fifo #(
  parameter int WIDTH = 31,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign head    = empty ? '0 : mem[rd_ptr];

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-2 depth).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vecmac_acc_drain.sv
// Accumulates cfg_len consecutive adder-tree sums into one dot-product result
// and offers results on a valid/ready port through a small FWFT FIFO.
// Optional build macro: VECMAC_ACC_PERF_EN adds perf_beats/perf_drops counters.
//
// Result port handshake: a result transfers on any rising edge where
// res_valid && res_ready; while res_valid is high and res_ready low, res_valid
// and res_data hold. The upstream tree cannot be stalled, so a result that
// completes while the FIFO is full (and nothing pops that edge) is dropped and
// flagged on the sticky err_drop. busy mirrors the FSM state (high in ACCUM).
module vecmac_acc_drain
  import vecmac_pkg::*;
#(
  parameter int  LANES      = DEF_LANES,
  parameter int  INW        = DEF_INW,
  parameter int  LENW       = 12,
  parameter int  FIFO_DEPTH = 4,
  localparam int SUMW       = calc_sumw(LANES, INW),
  localparam int ACCW       = SUMW + LENW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [SUMW-1:0] sum_in,
  input  logic [LENW-1:0] cfg_len,
  output logic            busy,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [ACCW-1:0] res_data,
  output logic            err_drop
`ifdef VECMAC_ACC_PERF_EN
  ,
  output logic [31:0]     perf_beats,
  output logic [15:0]     perf_drops
`endif
);

  acc_state_e      state, state_nxt;
  logic [ACCW-1:0] acc, acc_nxt;
  logic [LENW-1:0] cnt, cnt_nxt;
  logic [LENW-1:0] len_q, len_nxt;

  logic [ACCW-1:0] sum_ext;
  logic [ACCW-1:0] acc_sum;
  logic [LENW-1:0] cnt_inc;
  logic [LENW-1:0] len_eff;

  logic            push;
  logic [ACCW-1:0] push_data;
  logic            fifo_full;
  logic            fifo_empty;
  logic            drop;

  assign sum_ext = ACCW'(sum_in);
  assign acc_sum = acc + sum_ext;
  assign cnt_inc = cnt + LENW'(1);
  assign len_eff = (cfg_len == '0) ? LENW'(1) : cfg_len;

  assign busy      = (state == S_ACCUM);
  assign res_valid = !fifo_empty;
  // A pop while full frees the slot the push lands in, so only an un-popped full FIFO drops.
  assign drop      = push && fifo_full && !res_ready;

  // Next-state, accumulator and FIFO push decode.
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    len_nxt   = len_q;
    push      = 1'b0;
    push_data = acc_sum;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          len_nxt = len_eff;
          acc_nxt = sum_ext;
          cnt_nxt = LENW'(1);
          if (len_eff == LENW'(1)) begin
            push      = 1'b1;
            push_data = sum_ext;
          end else begin
            state_nxt = S_ACCUM;
          end
        end
      end
      S_ACCUM: begin
        if (in_valid) begin
          acc_nxt = acc_sum;
          cnt_nxt = cnt_inc;
          if (cnt_inc == len_q) begin
            push      = 1'b1;
            push_data = acc_sum;
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register, accumulator, beat counter and latched block length.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      acc   <= '0;
      cnt   <= '0;
      len_q <= '0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      len_q <= len_nxt;
    end
  end

  // Sticky drop flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_drop <= 1'b0;
    else if (drop) err_drop <= 1'b1;
  end

`ifdef VECMAC_ACC_PERF_EN
  // Saturating beat and drop counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_beats <= '0;
      perf_drops <= '0;
    end else begin
      if (in_valid && (perf_beats != '1)) perf_beats <= perf_beats + 32'd1;
      if (drop && (perf_drops != '1))     perf_drops <= perf_drops + 16'd1;
    end
  end
`else
  // Performance counters are not built in this configuration.
`endif

  vecmac_res_fifo #(
    .WIDTH (ACCW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (res_ready),
    .head      (res_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule
